// File: rtl/ahb_pkg.sv
// Shared AHB-lite types for the master and the ahb_slave responder.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_RD   = 2'b01,
        D_WR   = 2'b10
    } dphase_t;

endpackage

// File: rtl/ahb_master.sv
// AHB-lite single-initiator master: valid/ready commands become pipelined NONSEQ
// single transfers; one response pulse per completed transfer.
//
// data-phase state | meaning
// D_IDLE           | no transfer in the data phase
// D_RD             | read in the data phase, hrdata captured when hready=1
// D_WR             | write in the data phase, hwdata driven from the phase register
module ahb_master
    import ahb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int cntWidth  = 16
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic [1:0]           htrans,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic [cntWidth-1:0]  wr_count,
    output logic [cntWidth-1:0]  rd_count
);

    htrans_t              ap_trans, ap_trans_nxt;
    logic [dataWidth-1:0] ap_wdata, ap_wdata_nxt;
    dphase_t              dp_state, dp_state_nxt;

    logic [addrWidth-1:0] haddr_nxt;
    logic                 hwrite_nxt;
    logic [dataWidth-1:0] hwdata_nxt;
    logic                 rsp_valid_nxt;
    logic                 rsp_write_nxt;
    logic [dataWidth-1:0] rsp_rdata_nxt;
    logic [cntWidth-1:0]  wr_count_nxt;
    logic [cntWidth-1:0]  rd_count_nxt;

    // The slave's hready both ends the data phase and frees the address phase.
    assign cmd_ready = hready;
    assign htrans    = ap_trans;

    always_comb begin
        ap_trans_nxt  = ap_trans;
        ap_wdata_nxt  = ap_wdata;
        dp_state_nxt  = dp_state;
        haddr_nxt     = haddr;
        hwrite_nxt    = hwrite;
        hwdata_nxt    = hwdata;
        rsp_valid_nxt = 1'b0;
        rsp_write_nxt = rsp_write;
        rsp_rdata_nxt = rsp_rdata;
        wr_count_nxt  = wr_count;
        rd_count_nxt  = rd_count;

        if (hready) begin
            if (ap_trans == NONSEQ) begin
                dp_state_nxt = hwrite ? D_WR : D_RD;
                if (hwrite) begin
                    hwdata_nxt = ap_wdata;
                end
            end else begin
                dp_state_nxt = D_IDLE;
            end

            // haddr/hwrite keep their last values while the address phase is idle
            if (cmd_valid) begin
                ap_trans_nxt = NONSEQ;
                haddr_nxt    = cmd_addr;
                hwrite_nxt   = cmd_write;
                ap_wdata_nxt = cmd_wdata;
            end else begin
                ap_trans_nxt = IDLE;
            end

            case (dp_state)
                D_RD: begin
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b0;
                    rsp_rdata_nxt = hrdata;
                    rd_count_nxt  = rd_count + cntWidth'(1);
                end
                D_WR: begin
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    wr_count_nxt  = wr_count + cntWidth'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            ap_trans  <= IDLE;
            ap_wdata  <= '0;
            dp_state  <= D_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            ap_trans  <= ap_trans_nxt;
            ap_wdata  <= ap_wdata_nxt;
            dp_state  <= dp_state_nxt;
            haddr     <= haddr_nxt;
            hwrite    <= hwrite_nxt;
            hwdata    <= hwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_write <= rsp_write_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            wr_count  <= wr_count_nxt;
            rd_count  <= rd_count_nxt;
        end
    end

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- Single-initiator AHB-lite master; converts a valid/ready command stream into pipelined NONSEQ single transfers on the AHB bus.
- Returns one response per command: read data or write-complete.
- Sits between testbench/agent logic and an ahb_slave-style responder.
- Supports IDLE/NONSEQ only; no bursts, no hresp handling.

Parameters:
- addrWidth, 8, width of haddr and cmd_addr.
- dataWidth, 32, width of hwdata, hrdata, cmd_wdata and rsp_rdata.
- cntWidth, 16, width of the completed-transfer counters.

Ports:
- hclk  input  1  bus clock; all logic on its rising edge.
- hreset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this edge when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  addrWidth  transfer address.
- cmd_wdata  input  dataWidth  write data (ignored for reads).
- htrans  output  2  IDLE=2'b00 or NONSEQ=2'b10.
- haddr  output  addrWidth  address-phase address.
- hwrite  output  1  address-phase direction.
- hwdata  output  dataWidth  data-phase write data.
- hready  input  1  from slave; low inserts wait states.
- hrdata  input  dataWidth  from slave; valid at the data-phase-ending edge.
- rsp_valid  output  1  one-cycle pulse per completed transfer.
- rsp_write  output  1  direction of the completed transfer.
- rsp_rdata  output  dataWidth  read data (0 for writes).
- wr_count  output  cntWidth  completed writes.
- rd_count  output  cntWidth  completed reads.

Behaviour:
- All outputs are registered, except cmd_ready, which is combinational and equals hready.
- Reset values (any edge with hreset=1): htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, wr_count=0, rd_count=0.
- Reset also clears both phase registers. In-flight transfers are dropped and produce no response.
- Two pipeline stages:
  - Address-phase register (AP): IDLE / NONSEQ plus addr, write, wdata.
  - Data-phase register (DP): D_IDLE / D_RD / D_WR plus wdata.
- Edge with hready=1 (the bus advances):
  - DP <= AP, so hwdata <= AP.wdata when AP is a write, else hwdata holds its value.
  - AP <= accepted command if cmd_valid, else AP <= IDLE.
  - If DP was D_RD: the transfer completes. rsp_valid=1, rsp_write=0, rsp_rdata=hrdata, rd_count++.
  - If DP was D_WR: the transfer completes. rsp_valid=1, rsp_write=1, rsp_rdata=0, wr_count++.
  - If DP was D_IDLE: rsp_valid=0.
- Edge with hready=0 (wait state):
  - AP, DP, htrans, haddr, hwrite and hwdata all hold.
  - No command is accepted; rsp_valid=0.
- htrans/haddr/hwrite always reflect AP. When AP is IDLE, haddr and hwrite hold their last values.
- Latency, zero wait states: command accepted at edge k, address phase after k, data phase after k+1, rsp_valid high after k+2 (two cycles).
- Each wait cycle, in either phase, adds one cycle of latency.
- Back-to-back: a command can be accepted every cycle with hready=1, giving one completed transfer per cycle sustained.
- Read-after-write to the same address is issued with no stall. Ordering is guaranteed by the AHB pipeline.
- Counters wrap from 2^cntWidth-1 to 0.
- rsp has no backpressure. The consumer must take every pulse.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - dphase_t enum: D_IDLE, D_RD, D_WR.
  - This package is also reused by ahb_slave.
- No sub-module: two pipeline registers plus counters fit in one module.

Test Plan:
- Single write then read, slave never busy: cmd write 0x10/0xDEADBEEF, then read 0x10.
  - htrans=NONSEQ for one cycle each.
  - Write rsp_valid 2 cycles after accept; read rsp_rdata=0xDEADBEEF.
  - wr_count=1, rd_count=1.
- Back-to-back 4 writes (0x00..0x03, data 0xA0..0xA3), then 4 reads.
  - One accept per cycle.
  - Read responses 0xA0..0xA3 in order on consecutive cycles.
- Wait states: slave_busy asserted 3 cycles during the data phase of a write to 0x20.
  - haddr/htrans/hwdata stable throughout; cmd_ready=0 for 3 cycles.
  - rsp_valid delayed exactly 3 cycles; mem[0x20] correct.
- Idle gaps: cmd_valid low between transfers.
  - htrans=IDLE in the gaps; no spurious rsp_valid; counters unchanged.
- Reset mid-transfer: hreset=1 for 1 cycle while a read is in the data phase.
  - Next cycle: htrans=IDLE, hwdata=0, no rsp_valid for the dropped read.
  - Counters=0; the next command completes normally.
- Counter wrap with cntWidth=2: 5 writes.
  - wr_count sequence 1, 2, 3, 0, 1.
